tlk2711_rx_framer: RTL and testbench

//  Receive-side framer between the TLK2711-A parallel RX pins (rxd/rkmsb/rklsb, already retimed into clk)
//  and the TLK2711 RX DMA write engine. Acquires idle sync, delineates SOF/len/payload/[cksum]/EOF frames,

---
 rtl/tlk2711_rx_framer.sv | 146 ++++++++++++++
 tb/tb_tlk2711_rx_framer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rx_framer.sv
// tlk2711_rx_framer: receive framer between TLK2711-A RX pins and the RX DMA write engine
// Acquires idle sync, delineates SOF/len/payload/[cksum]/EOF frames, buffers payload in a FIFO.
// Ports: clk, arst_n (async active-low); i_rx_en; i_2711_rxd/i_2711_rkmsb/i_2711_rklsb (retimed RX word);
//   o_data/o_valid/o_last/i_ready (payload stream); o_frame_done/o_frame_err/o_err_code/o_frame_len
//   (per-frame status, code = {len_err, cksum_err, ovf_err}); o_loss (loss-of-signal level).
// Define TLK2711_RX_CKSUM_EN to expect a 16-bit payload sum word between the payload and EOF.
module tlk2711_rx_framer #(
  parameter int DLEN_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_IDLES = 4,
  parameter int LOS_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_rx_en,
  input  logic [15:0]           i_2711_rxd,
  input  logic                  i_2711_rkmsb,
  input  logic                  i_2711_rklsb,
  output logic [15:0]           o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [2:0]            o_err_code,
  output logic [DLEN_WIDTH-1:0] o_frame_len,
  output logic                  o_loss
);
`ifdef TLK2711_RX_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SYNC_IDLES + 1);
  localparam int LW = $clog2(LOS_CYCLES + 1);
  typedef enum logic [2:0] {HUNT, SYNC, HDR, PAY, CK, EOFW, ABORT} state_t;
  state_t state_q, state_d;
  logic [16:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [SW-1:0] idl_q, idl_d;
  logic [LW-1:0] los_q, los_d;
  logic [DLEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, flen_q, flen_d, cnt_inc, hdr_len;
  logic [15:0] sum_q, sum_d;
  logic [2:0] flg_q, flg_d, code_q, code_d;
  logic loss_q, loss_d, done_q, done_d, ferr_q, ferr_d;
  logic is_data, is_idle, is_sof, is_eof, is_err, los_hit, in_frame, ok_w, bad_w;
  logic empty, full, pop, room, pay_w, push, last_pay, close_good, close_bad;
  logic [16:0] push_w;
  assign is_data = !i_2711_rkmsb && !i_2711_rklsb;
  assign is_idle = !i_2711_rkmsb && i_2711_rklsb && i_2711_rxd == 16'h50BC;
  assign is_sof = !i_2711_rkmsb && i_2711_rklsb && i_2711_rxd == 16'h50FB;
  assign is_eof = !i_2711_rkmsb && i_2711_rklsb && i_2711_rxd == 16'h50FD;
  // unknown K codes count as line errors alongside rkmsb&rklsb
  assign is_err = !(is_data || is_idle || is_sof || is_eof);
  assign hdr_len = DLEN_WIDTH'(i_2711_rxd);
  assign cnt_inc = cnt_q + DLEN_WIDTH'(1);
  assign last_pay = cnt_inc == len_q;
  assign los_hit = is_err && los_q == LW'(LOS_CYCLES - 1);
  // inside a frame only the expected word or an IDLE is legal; anything else aborts
  assign in_frame = state_q inside {HDR, PAY, CK, EOFW};
  assign ok_w = state_q == EOFW ? is_eof : is_data;
  assign bad_w = in_frame && !is_idle && !ok_w;
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign pop = !empty && i_ready;
  assign room = !full || pop;
  assign pay_w = state_q == PAY && is_data;
  assign push = i_rx_en && room && (pay_w || state_q == ABORT);
  assign push_w = state_q == ABORT ? 17'h10000 : {last_pay, i_2711_rxd};
  // a zero-length or overflowed frame still needs a last beat, so it closes through ABORT
  assign close_good = i_rx_en && state_q == EOFW && is_eof && !flg_q[2] && !flg_q[0];
  assign close_bad = i_rx_en && state_q == ABORT && room;
  assign o_valid = !empty;
  assign {o_last, o_data} = empty ? 17'h0 : mem_q[rd_q[AW-1:0]];
  assign o_frame_done = done_q;
  assign o_frame_err = ferr_q;
  assign o_err_code = code_q;
  assign o_frame_len = flen_q;
  assign o_loss = loss_q;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q <= HUNT;
      wr_q <= '0;
      rd_q <= '0;
      idl_q <= '0;
      los_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      flen_q <= '0;
      sum_q <= '0;
      flg_q <= '0;
      code_q <= '0;
      loss_q <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      idl_q <= idl_d;
      los_q <= los_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      flen_q <= flen_d;
      sum_q <= sum_d;
      flg_q <= flg_d;
      code_q <= code_d;
      loss_q <= loss_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= push_w;
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    state_d = is_idle && idl_q == SW'(SYNC_IDLES - 1) ? SYNC : HUNT;
      SYNC:    state_d = los_hit ? HUNT : is_sof ? HDR : SYNC;
      HDR:     state_d = is_data ? (hdr_len == '0 ? EOFW : PAY) : HDR;
      PAY:     state_d = is_data && last_pay ? (CK_EN ? CK : EOFW) : PAY;
      CK:      state_d = is_data ? EOFW : CK;
      EOFW:    state_d = is_eof ? (close_good ? SYNC : ABORT) : EOFW;
      ABORT:   state_d = room ? (loss_q || los_hit ? HUNT : SYNC) : ABORT;
      default: state_d = HUNT;
    endcase
    if (bad_w) state_d = ABORT;
    if (!i_rx_en) state_d = HUNT;
  end
  always_comb begin
    idl_d = state_q == HUNT && is_idle && i_rx_en ? idl_q + SW'(1) : '0;
    los_d = !is_err ? '0 : los_q == LW'(LOS_CYCLES) ? los_q : los_q + LW'(1);
    loss_d = los_hit ? 1'b1 : state_q == HUNT && state_d == SYNC ? 1'b0 : loss_q;
    len_d = state_q == SYNC && is_sof ? '0 : state_q == HDR && is_data ? hdr_len : len_q;
    cnt_d = state_q == HDR ? '0 : pay_w ? cnt_inc : cnt_q;
    sum_d = state_q == HDR ? '0 : pay_w ? sum_q + i_2711_rxd : sum_q;
    flg_d = state_q == SYNC && is_sof ? '0 : flg_q | {bad_w || (state_q == HDR && is_data && hdr_len == '0),
            CK_EN && state_q == CK && is_data && i_2711_rxd != sum_q, pay_w && !room};
    done_d = close_good || close_bad;
    ferr_d = close_bad || (close_good && flg_q[1]);
    code_d = done_d ? flg_q : code_q;
    flen_d = done_d ? len_q : flen_q;
    wr_d = i_rx_en ? wr_q + (AW+1)'(push) : '0;
    rd_d = i_rx_en ? rd_q + (AW+1)'(pop) : '0;
  end
endmodule

// File: tb/tb_tlk2711_rx_framer.sv
// tb_tlk2711_rx_framer: scoreboard bench for tlk2711_rx_framer
module tb_tlk2711_rx_framer;
  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic i_rx_en = 1'b1;
  logic i_ready = 1'b1;
  logic rkmsb = 1'b0;
  logic rklsb = 1'b0;
  logic [15:0] rxd = 16'h0;
  logic [15:0] o_data, o_frame_len;
  logic o_valid, o_last, o_frame_done, o_frame_err, o_loss;
  logic [2:0] o_err_code;
  logic [16:0] exp_q[$];
  logic [16:0] exp_b;
  logic dn_err = 1'b0;
  int checks = 0;
  int errors = 0;
  int dn_cnt = 0;
  int d0;
  always #5 clk = ~clk;
  tlk2711_rx_framer dut (
    .clk(clk), .arst_n(arst_n), .i_rx_en(i_rx_en), .i_2711_rxd(rxd), .i_2711_rkmsb(rkmsb),
    .i_2711_rklsb(rklsb), .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_err_code(o_err_code),
    .o_frame_len(o_frame_len), .o_loss(o_loss)
  );
  // samples outputs 1 time unit after the edge, i.e. exactly what the next edge will accept
  task automatic tick();
    if (o_frame_done) begin
      dn_cnt++;
      dn_err = o_frame_err;
    end
    if (o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got last=%b data=%h, required no beat", o_last, o_data);
      end else begin
        exp_b = exp_q.pop_front();
        if ({o_last, o_data} !== exp_b) begin
          errors++;
          $display("FAIL beat: got last=%b data=%h, required last=%b data=%h", o_last, o_data, exp_b[16], exp_b[15:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic w(input logic [1:0] k, input logic [15:0] d);
    {rkmsb, rklsb} = k;
    rxd = d;
    tick();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) w(2'b01, 16'h50BC);
  endtask
  task automatic sof();
    w(2'b01, 16'h50FB);
  endtask
  task automatic eof();
    w(2'b01, 16'h50FD);
  endtask
  task automatic dat(input logic [15:0] d);
    w(2'b00, d);
  endtask
  task automatic err(input int n);
    for (int i = 0; i < n; i++) w(2'b11, 16'hDEAD);
  endtask
  task automatic drain();
    for (int t = 0; t < 300 && (exp_q.size() > 0 || o_valid); t++) idle(1);
    checks++;
    if (exp_q.size() > 0 || o_valid) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding valid=%b, required 0", exp_q.size(), o_valid);
    end
  endtask
  task automatic good_frame(input int n, input logic [15:0] base);
    logic [15:0] s = 16'h0;
    logic [15:0] v;
    sof();
    dat(16'(n));
    for (int i = 0; i < n; i++) begin
      v = base * 16'(i + 1);
      s = s + v;
      exp_q.push_back({i == n - 1, v});
      dat(v);
    end
`ifdef TLK2711_RX_CKSUM_EN
    dat(s);
`endif
    eof();
  endtask
  task automatic test_reset();
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_last, o_frame_done, o_frame_err, o_loss} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {o_valid, o_last, o_frame_done, o_frame_err, o_loss});
    end
    checks++;
    if (o_data !== 16'h0 || o_err_code !== 3'b0 || o_frame_len !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got data=%h code=%b len=%0d, required 0", o_data, o_err_code, o_frame_len);
    end
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    idle(4);
  endtask
  task automatic test_good_frame();
    d0 = dn_cnt;
    good_frame(3, 16'h1111);
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b0) begin
      errors++;
      $display("FAIL good_done: got pulses=%0d err=%b, required 1 err=0", dn_cnt - d0, dn_err);
    end
    checks++;
    if (o_frame_len !== 16'd3 || o_err_code !== 3'b000) begin
      errors++;
      $display("FAIL good_status: got len=%0d code=%b, required len=3 code=000", o_frame_len, o_err_code);
    end
  endtask
`ifdef TLK2711_RX_CKSUM_EN
  task automatic test_cksum();
    d0 = dn_cnt;
    sof();
    dat(16'd3);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({i == 3, 16'h1111 * 16'(i)});
      dat(16'h1111 * 16'(i));
    end
    dat(16'h6667);
    eof();
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b1 || o_err_code !== 3'b010) begin
      errors++;
      $display("FAIL cksum: got pulses=%0d err=%b code=%b, required 1 err=1 code=010", dn_cnt - d0, dn_err, o_err_code);
    end
  endtask
`endif
  task automatic test_len_err();
    d0 = dn_cnt;
    sof();
    dat(16'd5);
    exp_q.push_back({1'b0, 16'hAAAA});
    dat(16'hAAAA);
    exp_q.push_back({1'b0, 16'h5555});
    dat(16'h5555);
    exp_q.push_back(17'h10000);
    eof();
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b1 || o_err_code !== 3'b100 || o_frame_len !== 16'd5) begin
      errors++;
      $display("FAIL len_err: got pulses=%0d err=%b code=%b len=%0d, required 1 1 100 5", dn_cnt - d0, dn_err, o_err_code, o_frame_len);
    end
  endtask
  task automatic test_zero_len();
    d0 = dn_cnt;
    sof();
    dat(16'd0);
    idle(2);
    checks++;
    if (dn_cnt != d0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait: got pulses=%0d valid=%b before EOF, required 0 0", dn_cnt - d0, o_valid);
    end
    exp_q.push_back(17'h10000);
    eof();
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b1 || o_err_code !== 3'b100 || o_frame_len !== 16'd0) begin
      errors++;
      $display("FAIL zero_len: got pulses=%0d err=%b code=%b len=%0d, required 1 1 100 0", dn_cnt - d0, dn_err, o_err_code, o_frame_len);
    end
  endtask
  task automatic test_back_to_back();
    d0 = dn_cnt;
    good_frame(2, 16'h0101);
    good_frame(1, 16'h0007);
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 2 || dn_err !== 1'b0 || o_frame_len !== 16'd1) begin
      errors++;
      $display("FAIL back_to_back: got pulses=%0d err=%b len=%0d, required 2 0 1", dn_cnt - d0, dn_err, o_frame_len);
    end
  endtask
  task automatic test_overflow();
    logic [15:0] s = 16'h0;
    d0 = dn_cnt;
    i_ready = 1'b0;
    sof();
    dat(16'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 16'h0100 + 16'(i)});
      s = s + 16'h0100 + 16'(i);
      dat(16'h0100 + 16'(i));
    end
`ifdef TLK2711_RX_CKSUM_EN
    dat(s);
`endif
    exp_q.push_back(17'h10000);
    eof();
    idle(5);
    checks++;
    if (o_valid !== 1'b1 || dn_cnt != d0 || o_data !== 16'h0100) begin
      errors++;
      $display("FAIL ovf_hold: got valid=%b pulses=%0d data=%h, required 1 0 0100", o_valid, dn_cnt - d0, o_data);
    end
    i_ready = 1'b1;
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b1 || o_err_code[0] !== 1'b1 || o_err_code !== 3'b001 || o_frame_len !== 16'd20) begin
      errors++;
      $display("FAIL overflow: got pulses=%0d err=%b code=%b len=%0d, required 1 1 001 20", dn_cnt - d0, dn_err, o_err_code, o_frame_len);
    end
  endtask
  task automatic test_async_reset();
    i_ready = 1'b0;
    sof();
    dat(16'd3);
    dat(16'h7777);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got valid=%b, required 1", o_valid);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_frame_done !== 1'b0 || o_err_code !== 3'b0 || o_frame_len !== 16'h0) begin
      errors++;
      $display("FAIL arst_mid: got valid=%b done=%b code=%b len=%0d, required all 0", o_valid, o_frame_done, o_err_code, o_frame_len);
    end
    @(posedge clk);
    #1 arst_n = 1'b1;
    i_ready = 1'b1;
    d0 = dn_cnt;
    idle(4);
    good_frame(1, 16'h0909);
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b0 || o_frame_len !== 16'd1) begin
      errors++;
      $display("FAIL arst_recover: got pulses=%0d err=%b len=%0d, required 1 0 1", dn_cnt - d0, dn_err, o_frame_len);
    end
  endtask
  task automatic test_loss();
    d0 = dn_cnt;
    sof();
    dat(16'd4);
    exp_q.push_back({1'b0, 16'h0A0A});
    dat(16'h0A0A);
    exp_q.push_back(17'h10000);
    err(63);
    checks++;
    if (o_loss !== 1'b0) begin
      errors++;
      $display("FAIL loss_63: got loss=%b, required 0", o_loss);
    end
    err(1);
    checks++;
    if (o_loss !== 1'b1) begin
      errors++;
      $display("FAIL loss_64: got loss=%b, required 1", o_loss);
    end
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b1 || o_err_code !== 3'b100) begin
      errors++;
      $display("FAIL loss_abort: got pulses=%0d err=%b code=%b, required 1 1 100", dn_cnt - d0, dn_err, o_err_code);
    end
    idle(3);
    checks++;
    if (o_loss !== 1'b1) begin
      errors++;
      $display("FAIL loss_hold: got loss=%b after 3 idles, required 1", o_loss);
    end
    idle(1);
    checks++;
    if (o_loss !== 1'b0) begin
      errors++;
      $display("FAIL loss_clear: got loss=%b after 4 idles, required 0", o_loss);
    end
    drain();
    d0 = dn_cnt;
    good_frame(2, 16'h0505);
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b0) begin
      errors++;
      $display("FAIL loss_recover: got pulses=%0d err=%b, required 1 0", dn_cnt - d0, dn_err);
    end
  endtask
  task automatic test_enable();
    d0 = dn_cnt;
    i_ready = 1'b0;
    sof();
    dat(16'd4);
    dat(16'h4321);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_pre: got valid=%b, required 1", o_valid);
    end
    i_rx_en = 1'b0;
    idle(1);
    checks++;
    if (o_valid !== 1'b0 || o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL en_flush: got valid=%b done=%b, required 0 0", o_valid, o_frame_done);
    end
    i_rx_en = 1'b1;
    i_ready = 1'b1;
    sof();
    dat(16'd2);
    dat(16'hDEAD);
    dat(16'hBEEF);
    eof();
    idle(2);
    checks++;
    if (dn_cnt != d0 || o_valid !== 1'b0 || o_loss !== 1'b0) begin
      errors++;
      $display("FAIL en_hunt: got pulses=%0d valid=%b loss=%b, required 0 0 0", dn_cnt - d0, o_valid, o_loss);
    end
    idle(4);
    good_frame(3, 16'h0202);
    idle(2);
    drain();
    checks++;
    if (dn_cnt - d0 !== 1 || dn_err !== 1'b0 || o_frame_len !== 16'd3) begin
      errors++;
      $display("FAIL en_recover: got pulses=%0d err=%b len=%0d, required 1 0 3", dn_cnt - d0, dn_err, o_frame_len);
    end
  endtask
  initial begin
    test_reset();
    test_good_frame();
`ifdef TLK2711_RX_CKSUM_EN
    test_cksum();
`endif
    test_len_err();
    test_zero_len();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_loss();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
